// File: rtl/l2_rr_arbiter.sv
// Round-robin arbiter sharing one L2 line port among NUM_PORTS cache ports; IDLE->GRANT->DONE, strobe 1 cycle after request.
// Losing ports are held off, never dropped; req_resp follows l2_resp combinationally while granted.
module l2_rr_arbiter #(
  parameter int                   NUM_PORTS     = 2,
  parameter int                   ADDR_WIDTH    = 32,
  parameter int                   LINE_WIDTH    = 256,
  parameter logic [NUM_PORTS-1:0] WRITE_EN_MASK = '1,
  localparam int                  GW            = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_PORTS-1:0]             req_read,
  input  logic [NUM_PORTS-1:0]             req_write,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_address,
  input  logic [NUM_PORTS*LINE_WIDTH-1:0]  req_wdata,
  output logic [LINE_WIDTH-1:0]            req_rdata,
  output logic [NUM_PORTS-1:0]             req_resp,
  output logic                             l2_read,
  output logic                             l2_write,
  output logic [ADDR_WIDTH-1:0]            l2_address,
  output logic [LINE_WIDTH-1:0]            l2_wdata,
  input  logic [LINE_WIDTH-1:0]            l2_rdata,
  input  logic                             l2_resp,
  output logic [GW-1:0]                    grant_id,
  output logic                             busy
);

  typedef enum logic [1:0] {IDLE, GRANT, DONE} state_t;

  state_t                state;
  logic [GW-1:0]         rr_ptr;
  logic [NUM_PORTS-1:0]  active;
  logic                  found;
  logic [GW-1:0]         winner;
  int                    idx;
  logic                  in_grant;

  assign active = req_read | (req_write & WRITE_EN_MASK);

  // First active port at or above rr_ptr, wrapping modulo NUM_PORTS.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      if (!found && active[idx]) begin
        found  = 1'b1;
        winner = GW'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      grant_id <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            grant_id <= winner;
            state    <= GRANT;
          end
        end
        GRANT: begin
          // Completion wins over a simultaneous request drop.
          if (l2_resp) begin
            rr_ptr <= (int'(grant_id) == NUM_PORTS - 1) ? '0 : grant_id + 1'b1;
            state  <= DONE;
          end else if (!active[grant_id]) begin
            state <= IDLE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign in_grant   = (state == GRANT);
  assign busy       = (state != IDLE);
  assign l2_read    = in_grant & req_read[grant_id];
  assign l2_write   = in_grant & req_write[grant_id] & WRITE_EN_MASK[grant_id];
  assign l2_address = req_address[int'(grant_id)*ADDR_WIDTH +: ADDR_WIDTH];
  assign l2_wdata   = req_wdata[int'(grant_id)*LINE_WIDTH +: LINE_WIDTH];
  assign req_resp   = (in_grant && l2_resp) ? (NUM_PORTS'(1) << grant_id) : '0;
  assign req_rdata  = l2_rdata;

endmodule

// File: tb/tb_l2_rr_arbiter.sv
// Directed bench: two-port arbiter (full and partial write mask) and a four-port instance.
module tb_l2_rr_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [255:0] l2_rdata = 256'h0123_4567_89ab_cdef_fedc_ba98_7654_3210_1111_2222_3333_4444_5555_6666_7777_8888;

  // Two ports, both writable
  logic [1:0]   a_rd = '0, a_wr = '0, a_resp_o;
  logic [63:0]  a_addr = '0;
  logic [511:0] a_wd = '0;
  logic [255:0] a_rdata, a_wdata;
  logic [31:0]  a_address;
  logic         a_l2rd, a_l2wr, a_resp = 1'b0, a_busy;
  logic [0:0]   a_gid;

  // Two ports, port 0 read-only
  logic [1:0]   m_rd = '0, m_wr = '0, m_resp_o;
  logic [63:0]  m_addr = '0;
  logic [63:0]  m_wd = '0;
  logic [31:0]  m_rdata, m_wdata, m_address;
  logic         m_l2rd, m_l2wr, m_resp = 1'b0, m_busy;
  logic [0:0]   m_gid;

  // Four ports
  logic [3:0]   q_rd = '0, q_wr = '0, q_resp_o;
  logic [127:0] q_addr = '0;
  logic [127:0] q_wd = '0;
  logic [31:0]  q_rdata, q_wdata, q_address;
  logic         q_l2rd, q_l2wr, q_resp = 1'b0, q_busy;
  logic [1:0]   q_gid;

  l2_rr_arbiter #(.NUM_PORTS(2), .ADDR_WIDTH(32), .LINE_WIDTH(256), .WRITE_EN_MASK(2'b11)) dut_a (
    .clk(clk), .rst(rst), .req_read(a_rd), .req_write(a_wr), .req_address(a_addr),
    .req_wdata(a_wd), .req_rdata(a_rdata), .req_resp(a_resp_o), .l2_read(a_l2rd),
    .l2_write(a_l2wr), .l2_address(a_address), .l2_wdata(a_wdata), .l2_rdata(l2_rdata),
    .l2_resp(a_resp), .grant_id(a_gid), .busy(a_busy));

  l2_rr_arbiter #(.NUM_PORTS(2), .ADDR_WIDTH(32), .LINE_WIDTH(32), .WRITE_EN_MASK(2'b10)) dut_m (
    .clk(clk), .rst(rst), .req_read(m_rd), .req_write(m_wr), .req_address(m_addr),
    .req_wdata(m_wd), .req_rdata(m_rdata), .req_resp(m_resp_o), .l2_read(m_l2rd),
    .l2_write(m_l2wr), .l2_address(m_address), .l2_wdata(m_wdata), .l2_rdata(l2_rdata[31:0]),
    .l2_resp(m_resp), .grant_id(m_gid), .busy(m_busy));

  l2_rr_arbiter #(.NUM_PORTS(4), .ADDR_WIDTH(32), .LINE_WIDTH(32), .WRITE_EN_MASK(4'b1111)) dut_q (
    .clk(clk), .rst(rst), .req_read(q_rd), .req_write(q_wr), .req_address(q_addr),
    .req_wdata(q_wd), .req_rdata(q_rdata), .req_resp(q_resp_o), .l2_read(q_l2rd),
    .l2_write(q_l2wr), .l2_address(q_address), .l2_wdata(q_wdata), .l2_rdata(l2_rdata[31:0]),
    .l2_resp(q_resp), .grant_id(q_gid), .busy(q_busy));

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full read grant on dut_a; entered in IDLE with requests already driven.
  task automatic a_cycle(input int g, input logic [31:0] addr);
    tick();
    chk("a_gid", a_gid, g);
    chk("a_busy_grant", a_busy, 1);
    chk("a_l2rd_grant", a_l2rd, 1);
    chk("a_l2addr", a_address, addr);
    chk("a_resp_before", a_resp_o, 0);
    a_resp = 1'b1; #1;
    chk("a_resp_pulse", a_resp_o, 2'b01 << g);
    tick();
    a_resp = 1'b0; #1;
    chk("a_busy_done", a_busy, 1);
    chk("a_l2rd_done", a_l2rd, 0);
    chk("a_resp_done", a_resp_o, 0);
    tick();
    chk("a_busy_idle", a_busy, 0);
  endtask

  // One full grant on dut_q; l2_resp is left high through DONE and must be ignored.
  task automatic q_cycle(input int g);
    tick();
    chk("q_gid", q_gid, g);
    chk("q_l2rd_grant", q_l2rd, 1);
    q_resp = 1'b1; #1;
    chk("q_resp_pulse", q_resp_o, 4'b0001 << g);
    tick();
    chk("q_resp_in_done", q_resp_o, 0);
    chk("q_busy_done", q_busy, 1);
    q_resp = 1'b0;
    tick();
    chk("q_busy_idle", q_busy, 0);
  endtask

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_busy", a_busy, 0);
    chk("rst_gid", a_gid, 0);
    chk("rst_l2rd", a_l2rd, 0);
    chk("rst_l2wr", a_l2wr, 0);
    chk("rst_resp", a_resp_o, 0);
    chk("rdata_pass", a_rdata, l2_rdata);
    rst = 1'b0;

    // Both ports reading continuously: grants 0,1,0,1, three cycles apart
    a_addr = {32'h0000_2000, 32'h0000_1000};
    a_rd = 2'b11; #1;
    chk("a_idle_l2rd", a_l2rd, 0);
    a_cycle(0, 32'h1000);
    a_cycle(1, 32'h2000);
    a_cycle(0, 32'h1000);
    a_cycle(1, 32'h2000);

    // Port 1 writes an A5-filled line to 0x100
    a_rd = 2'b00; a_wr = 2'b10;
    a_addr[63:32] = 32'h0000_0100;
    a_wd[511:256] = {32{8'hA5}};
    tick();
    chk("wr_gid", a_gid, 1);
    chk("wr_l2wr", a_l2wr, 1);
    chk("wr_l2rd", a_l2rd, 0);
    chk("wr_addr", a_address, 32'h100);
    chk("wr_wdata", a_wdata, {32{8'hA5}});
    a_resp = 1'b1; #1;
    chk("wr_resp", a_resp_o, 2'b10);
    tick();
    a_resp = 1'b0; a_wr = 2'b00; #1;
    chk("wr_done_l2wr", a_l2wr, 0);
    tick();

    // Abort: granted port 0 drops its request without l2_resp
    a_rd = 2'b01;
    tick();
    chk("ab_gid", a_gid, 0);
    a_rd = 2'b00; #1;
    chk("ab_l2rd", a_l2rd, 0);
    chk("ab_resp", a_resp_o, 0);
    tick();
    chk("ab_idle", a_busy, 0);
    a_rd = 2'b11;
    tick();
    chk("ab_ptr_kept", a_gid, 0);
    a_resp = 1'b1;
    tick();
    a_resp = 1'b0;
    tick();
    tick();
    chk("pre_rst_gid", a_gid, 1);
    chk("pre_rst_busy", a_busy, 1);

    // Reset mid-GRANT, then a stray l2_resp, then port 0 is favoured
    rst = 1'b1;
    tick();
    chk("mid_rst_busy", a_busy, 0);
    chk("mid_rst_l2rd", a_l2rd, 0);
    chk("mid_rst_gid", a_gid, 0);
    chk("mid_rst_resp", a_resp_o, 0);
    rst = 1'b0; a_rd = 2'b00; a_resp = 1'b1; #1;
    chk("stray_resp", a_resp_o, 0);
    tick();
    chk("stray_busy", a_busy, 0);
    a_resp = 1'b0; a_rd = 2'b11;
    tick();
    chk("post_rst_gid", a_gid, 0);
    chk("post_rst_l2rd", a_l2rd, 1);
    a_rd = 2'b00;
    tick();

    // Read-only port 0 asking only to write is never granted
    m_wr = 2'b01; m_rd = 2'b10;
    tick();
    chk("m_gid", m_gid, 1);
    chk("m_l2rd", m_l2rd, 1);
    chk("m_l2wr", m_l2wr, 0);
    m_resp = 1'b1; #1;
    chk("m_resp", m_resp_o, 2'b10);
    tick();
    m_resp = 1'b0; m_rd = 2'b00;
    tick();
    tick();
    chk("m_ro_idle", m_busy, 0);
    chk("m_ro_l2wr", m_l2wr, 0);
    m_rd = 2'b10;
    tick();
    chk("m_p1_again", m_gid, 1);
    chk("m_p1_busy", m_busy, 1);
    m_rd = 2'b00; m_wr = 2'b00;
    tick();

    // Four ports: advance rr_ptr to 2, stray l2_resp in IDLE, then ports 1 and 3
    q_rd = 4'b0010;
    q_cycle(1);
    q_rd = 4'b0000; q_resp = 1'b1; #1;
    chk("q_stray_resp", q_resp_o, 0);
    tick();
    chk("q_stray_busy", q_busy, 0);
    q_resp = 1'b0;
    q_rd = 4'b1010;
    q_cycle(3);
    q_cycle(1);
    q_cycle(3);
    q_cycle(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
